// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - RV32M multiply op encodings, sequencer states and magnitude helper
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
    return s ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - 64-bit conditional negate of the product plus hi/lo result word select
module mul_sign_fix (
  input  logic [63:0] p_in,
  input  logic        neg,
  input  logic        hi,
  output logic [63:0] p_out,
  output logic [31:0] word
);

  assign p_out = neg ? (~p_in + 64'd1) : p_in;
  assign word  = hi ? p_out[63:32] : p_out[31:0];

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - RV32M multiply sequencer driving an external unsigned_mul, with one-entry product cache
module mul_seq_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter bit EN_REUSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_o,
  output logic        busy_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_p_i
);

  import mul_pkg::*;

  localparam int CW = $clog2(MUL_LAT + 1);

  mul_state_e  state;
  logic [CW-1:0] cnt;
  mul_op_e     op_q;
  logic        neg_q;
  logic [31:0] rs1_q, rs2_q;
  logic        sa_q, sb_q;

  logic        c_vld;
  logic [31:0] c_rs1, c_rs2;
  logic        c_sa, c_sb;
  logic [63:0] c_p;

  mul_op_e     req_op;
  logic        sa, sb, hit;
  logic [63:0] fix_in, fix_p;
  logic        fix_neg, fix_hi;
  logic [31:0] fix_word;

  assign req_op = mul_op_e'(req_op_i);
  assign sa     = ((req_op == OP_MULH) || (req_op == OP_MULHSU)) && rs1_i[31];
  assign sb     = (req_op == OP_MULH) && rs2_i[31];

  // The low word is identical for signed and unsigned products, so MUL ignores cached signedness.
  assign hit = EN_REUSE && c_vld && (rs1_i == c_rs1) && (rs2_i == c_rs2) &&
               ((req_op == OP_MUL) || ({sa, sb} == {c_sa, c_sb}));

  // One sign-fix instance serves both the CALC completion and the cache-hit word select.
  assign fix_in  = (state == CALC) ? mul_p_i : c_p;
  assign fix_neg = (state == CALC) && neg_q;
  assign fix_hi  = (state == CALC) ? (op_q != OP_MUL) : (req_op != OP_MUL);

  mul_sign_fix u_sign_fix (
    .p_in  (fix_in),
    .neg   (fix_neg),
    .hi    (fix_hi),
    .p_out (fix_p),
    .word  (fix_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      c_vld       <= 1'b0;
      c_rs1       <= '0;
      c_rs2       <= '0;
      c_sa        <= 1'b0;
      c_sb        <= 1'b0;
      c_p         <= '0;
      req_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      res_o       <= '0;
      busy_o      <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && !flush_i) begin
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (hit) begin
              res_o       <= fix_word;
              res_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              mul_a_o <= mag32(rs1_i, sa);
              mul_b_o <= mag32(rs2_i, sb);
              op_q    <= req_op;
              neg_q   <= sa ^ sb;
              rs1_q   <= rs1_i;
              rs2_q   <= rs2_i;
              sa_q    <= sa;
              sb_q    <= sb;
              cnt     <= CW'(MUL_LAT - 1);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            res_o       <= fix_word;
            res_valid_o <= 1'b1;
            c_vld       <= 1'b1;
            c_rs1       <= rs1_q;
            c_rs2       <= rs2_q;
            c_sa        <= sa_q;
            c_sb        <= sb_q;
            c_p         <= fix_p;
            state       <= DONE;
          end
        end
        DONE: begin
          if (flush_i || res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          res_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl against an arithmetic RV32M reference
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res;
  logic        busy;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;

  int checks = 0;
  int errors = 0;

  logic        m_vld = 1'b0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0;
  logic        m_sa = 1'b0, m_sb = 1'b0;

  always #5 clk = ~clk;

  assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

  mul_seq_ctrl #(.MUL_LAT(2), .EN_REUSE(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .flush_i     (flush),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_o       (res),
    .busy_o      (busy),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_p_i     (mul_p)
  );

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic sgn_a(input logic [1:0] op, input logic [31:0] a);
    return (op == 2'b01 || op == 2'b10) && a[31];
  endfunction

  function automatic logic sgn_b(input logic [1:0] op, input logic [31:0] b);
    return (op == 2'b01) && b[31];
  endfunction

  function automatic logic model_hit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return m_vld && a == m_rs1 && b == m_rs2 &&
           (op == 2'b00 || (sgn_a(op, a) == m_sa && sgn_b(op, b) == m_sb));
  endfunction

  task automatic model_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    m_vld = 1'b1; m_rs1 = a; m_rs2 = b; m_sa = sgn_a(op, a); m_sb = sgn_b(op, b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and waits (bounded) for res_valid; lat counts edges from the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    req_op = op; rs1 = a; rs2 = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin tick(); lat++; end
    r = res;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] r, output int exp_lat, output logic [31:0] exp_r);
    logic h;
    h = model_hit(op, a, b);
    exp_lat = h ? 1 : 3;
    exp_r = ref_mul(op, a, b);
    do_req(op, a, b, lat, r);
    if (!h) model_store(op, a, b);
    release_res();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready, res_valid, busy, res, mul_a, mul_b} !== {1'b1, 1'b0, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL reset_state actual ready=%b valid=%b busy=%b res=%h a=%h b=%h required 1 0 0 0 0 0",
               req_ready, res_valid, busy, res, mul_a, mul_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000003, 32'h00000003};
    logic [31:0] want[5] = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD};
    int          wlat[5] = '{3, 3, 3, 3, 1};
    int lat, el;
    logic [31:0] r, er;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], lat, r, el, er);
      checks++;
      if (r !== want[i] || r !== er) begin
        errors++;
        $display("FAIL directed_res[%0d] actual %h required %h", i, r, want[i]);
      end
      checks++;
      if (lat != wlat[i] || lat != el) begin
        errors++;
        $display("FAIL directed_lat[%0d] actual %0d required %0d", i, lat, wlat[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b, er, r;
    int lat;
    a = $urandom() | 32'h80000000;
    b = $urandom();
    er = ref_mul(2'b10, a, b);
    do_req(2'b10, a, b, lat, r);
    model_store(2'b10, a, b);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid, req_ready, busy, res} !== {1'b1, 1'b0, 1'b1, er}) begin
        errors++;
        $display("FAIL stall_hold[%0d] actual valid=%b ready=%b busy=%b res=%h required 1 0 1 %h",
                 i, res_valid, req_ready, busy, res, er);
      end
      tick();
    end
    release_res();
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release actual valid=%b ready=%b required 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b, r, er, ea, eb;
    int lat, el;
    a = $urandom() | 32'h80000000;
    b = ($urandom() | 32'h80000000) ^ 32'h0000_0001;
    ea = ~a + 32'd1;
    eb = ~b + 32'd1;
    req_op = 2'b01; rs1 = a; rs2 = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (mul_a !== ea || mul_b !== eb) begin
      errors++;
      $display("FAIL calc_magnitude actual %h %h required %h %h", mul_a, mul_b, ea, eb);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc actual valid=%b ready=%b busy=%b required 0 1 0", res_valid, req_ready, busy);
    end
    repeat (4) tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result actual %b required 0", res_valid);
    end
    issue(2'b01, a, b, lat, r, el, er);
    checks++;
    if (lat != 3 || lat != el || r !== er) begin
      errors++;
      $display("FAIL flush_reissue actual lat=%0d res=%h required 3 %h", lat, r, er);
    end
    issue(2'b11, 32'd2, 32'd3, lat, r, el, er);
    checks++;
    if (r !== 32'h0 || lat != 3) begin
      errors++;
      $display("FAIL mulhu_small actual lat=%0d res=%h required 3 00000000", lat, r);
    end
    a = $urandom(); b = $urandom();
    do_req(2'b00, a, b, lat, r);
    model_store(2'b00, a, b);
    flush = 1'b1; res_ready = 1'b1;
    tick();
    flush = 1'b0; res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done actual valid=%b ready=%b required 0 1", res_valid, req_ready);
    end
    issue(2'b00, a, b, lat, r, el, er);
    checks++;
    if (lat != 1 || lat != el || r !== er) begin
      errors++;
      $display("FAIL flush_done_keeps_cache actual lat=%0d res=%h required 1 %h", lat, r, er);
    end
    req_op = 2'b11; rs1 = $urandom(); rs2 = $urandom(); req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_no_accept actual busy=%b ready=%b required 0 1", busy, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, r, er;
    int lat, el;
    req_op = 2'b11; rs1 = $urandom(); rs2 = $urandom(); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({req_ready, res_valid, busy, res, mul_a, mul_b} !== {1'b1, 1'b0, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL reset_in_calc actual ready=%b valid=%b busy=%b res=%h a=%h b=%h required 1 0 0 0 0 0",
               req_ready, res_valid, busy, res, mul_a, mul_b);
    end
    rst_n = 1'b1;
    m_vld = 1'b0;
    tick();
    a = $urandom(); b = $urandom();
    do_req(2'b01, a, b, lat, r);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({req_ready, res_valid, busy, res, mul_a, mul_b} !== {1'b1, 1'b0, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL reset_in_done actual ready=%b valid=%b busy=%b res=%h a=%h b=%h required 1 0 0 0 0 0",
               req_ready, res_valid, busy, res, mul_a, mul_b);
    end
    rst_n = 1'b1;
    tick();
    issue(2'b01, a, b, lat, r, el, er);
    checks++;
    if (lat != 3 || lat != el || r !== er) begin
      errors++;
      $display("FAIL reset_clears_cache actual lat=%0d res=%h required 3 %h", lat, r, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] specials [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] a, b, r, er;
    logic [1:0]  op;
    int lat, el;
    a = $urandom(); b = $urandom();
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom();
        b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom();
      end
      issue(op, a, b, lat, r, el, er);
      checks++;
      if (r !== er || lat != el) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h actual res=%h lat=%0d required res=%h lat=%0d",
                 i, op, a, b, r, lat, er, el);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
